// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder (I/U/J/B/S/Z/SH, 111 illegal) feeding a 2-entry ready/valid FIFO of {out, illegal}
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in,
  input  logic [2:0]      imm_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            illegal
);
  logic [31:0]   imm32;
  logic [XLEN:0] mem_q [2];
  logic [XLEN:0] mem_d [2];
  logic          wr_q, wr_d, rd_q, rd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          push, pop;
  always_comb begin
    imm32 = imm_sel == 3'd0 ? {{20{in[31]}}, in[31:20]} :
            imm_sel == 3'd1 ? {in[31:12], 12'b0} :
            imm_sel == 3'd2 ? {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0} :
            imm_sel == 3'd3 ? {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0} :
            imm_sel == 3'd4 ? {{21{in[31]}}, in[30:25], in[11:7]} :
            imm_sel == 3'd5 ? {27'b0, in[19:15]} :
            imm_sel == 3'd6 ? {26'b0, XLEN == 64 ? in[25] : 1'b0, in[24:20]} :
            32'b0;
  end
  assign in_ready  = cnt_q != 2'd2;
  assign out_valid = cnt_q != 2'd0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign {out, illegal} = mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {XLEN'($signed(imm32)), imm_sel == 3'd7};
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe at XLEN=32 plus directed XLEN=64 vectors
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid64 = 1'b0;
  logic        out_ready = 1'b0, out_ready64 = 1'b1;
  logic [31:0] in = '0;
  logic [2:0]  imm_sel = '0;
  logic        in_ready, out_valid, illegal;
  logic        in_ready64, out_valid64, illegal64;
  logic [31:0] out;
  logic [63:0] out64;
  logic [32:0] q[$];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in), .imm_sel(imm_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .illegal(illegal)
  );
  imm_gen_pipe #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64), .in(in), .imm_sel(imm_sel),
    .out_valid(out_valid64), .out_ready(out_ready64), .out(out64), .illegal(illegal64)
  );
  function automatic logic [64:0] model(logic [31:0] x, logic [2:0] s, int xl);
    logic signed [63:0] v;
    logic [63:0] r;
    r = '0;
    case (s)
      3'd0: begin v = {{32{x[31]}}, x}; v = v >>> 20; end
      3'd1: v = {{32{x[31]}}, x[31:12], 12'b0};
      3'd2: begin r[20] = x[31]; r[19:12] = x[19:12]; r[11] = x[20]; r[10:1] = x[30:21]; v = $signed(r << 43) >>> 43; end
      3'd3: begin r[12] = x[31]; r[11] = x[7]; r[10:5] = x[30:25]; r[4:1] = x[11:8]; v = $signed(r << 51) >>> 51; end
      3'd4: begin r[11:5] = x[31:25]; r[4:0] = x[11:7]; v = $signed(r << 52) >>> 52; end
      3'd5: v = x[19:15];
      3'd6: v = xl == 64 ? x[25:20] : x[24:20];
      default: v = '0;
    endcase
    return {v, s == 3'd7};
  endfunction
  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic ev, pu, po;
    logic [64:0] e;
    ev = q.size() != 0;
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, q.size() < 2);
    if (ev) chk("head", {out, illegal}, q[0]);
    pu = in_valid && q.size() < 2;
    po = ev && out_ready;
    e = model(in, imm_sel, 32);
    @(posedge clk); #1;
    if (po) void'(q.pop_front());
    if (pu) q.push_back(e[32:0]);
  endtask
  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out", {out, illegal}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in = 32'hFFF00093; imm_sel = 3'd0;
    tick();
    in_valid = 1'b0;
    chk("i_type", {out_valid, out, illegal}, {1'b1, 32'hFFFFFFFF, 1'b0});
    tick();
    in_valid = 1'b1; in = 32'hFE000EE3; imm_sel = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("b_type", out, 32'hFFFFFFFC);
    tick();
    in_valid = 1'b1; in = 32'h12345678; imm_sel = 3'd7;
    tick();
    in = 32'h000FD073; imm_sel = 3'd5;
    chk("illegal", {out, illegal}, {32'h0, 1'b1});
    tick();
    in_valid = 1'b0;
    chk("z_type", {out, illegal}, {32'h1F, 1'b0});
    tick();
    in_valid = 1'b1; in = 32'h03F00093; imm_sel = 3'd6;
    tick();
    in_valid = 1'b0;
    chk("sh32", out, 32'h1F);
    tick();
    in_valid64 = 1'b1; in = 32'h800000B7; imm_sel = 3'd1;
    tick();
    in_valid64 = 1'b0;
    chk("u64", {out_valid64, out64, illegal64}, {1'b1, 64'hFFFFFFFF80000000, 1'b0});
    in_valid64 = 1'b1; in = 32'h03F00093; imm_sel = 3'd6;
    tick();
    in_valid64 = 1'b0;
    chk("sh64", {out_valid64, out64}, {1'b1, 64'd63});
    tick();
    chk("drain64", out_valid64, 0);
    out_ready = 1'b0; in_valid = 1'b1; in = 32'h00100093; imm_sel = 3'd0;
    tick();
    in = 32'h00200093;
    tick();
    chk("bp_full", in_ready, 0);
    in = 32'h00300093;
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_head_a", out, 32'h1);
    tick();
    chk("bp_head_b", out, 32'h2);
    tick();
    chk("bp_empty", {out_valid, in_ready}, {1'b0, 1'b1});
    in_valid = 1'b1; out_ready = 1'b0; in = 32'h00500093;
    tick();
    tick();
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst", {out_valid, in_ready, out, illegal}, {1'b1 ? 2'b01 : 2'b00, 33'b0});
    q.delete();
    in = 32'h00700093;
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_head", {out_valid, out}, {1'b1, 32'h7});
    tick();
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in        = $urandom;
      imm_sel   = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in = $urandom;
      imm_sel = 3'(i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream offers an instruction.
REQ-005 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have port in  input  32  raw instruction word.
REQ-007 SHALL have port imm_sel  input  3  immediate format select, sampled with in.
REQ-008 SHALL have port out_valid  output  1  out and illegal hold a valid result.
REQ-009 SHALL have port out_ready  input  1  downstream consumes result this cycle.
REQ-010 SHALL have port out  output  XLEN  extended immediate.
REQ-011 SHALL have port illegal  output  1  result came from an unsupported imm_sel.

Function
REQ-012 SHALL decode imm_sel 000 I: in[31:20], sign-extended to XLEN.
REQ-013 SHALL decode 001 U: {in[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
REQ-014 SHALL decode 010 J: {in[31], in[19:12], in[20], in[30:21], 1'b0}, sign-extended.
REQ-015 SHALL decode 011 B: {in[31], in[7], in[30:25], in[11:8], 1'b0}, sign-extended.
REQ-016 SHALL decode 100 S: {in[31:25], in[11:7]}, sign-extended.
REQ-017 SHALL decode 101 Z (CSR zimm): in[19:15], zero-extended.
REQ-018 SHALL decode 110 SH (shift amount): in[25:20] zero-extended when XLEN=64, in[24:20] zero-extended when XLEN=32.
REQ-019 SHALL treat 111 as illegal: result out=0, illegal=1; all other formats produce illegal=0.
REQ-020 SHALL accept an instruction when in_valid and in_ready are both high at a rising edge (push).
REQ-021 SHALL release a result when out_valid and out_ready are both high at a rising edge (pop).
REQ-022 SHALL buffer results in a 2-entry FIFO holding {out, illegal}; decode is computed before storage.
REQ-023 SHALL drive in_ready = 1 when occupancy < 2, 0 when occupancy = 2, from registered state only (no combinational path from out_ready).
REQ-024 SHALL drive out_valid = 1 iff occupancy >= 1; out/illegal show the oldest entry.
REQ-025 SHALL give latency of one cycle: push at edge t with empty FIFO yields out_valid=1 after edge t.
REQ-026 SHALL preserve acceptance order; no entry dropped or duplicated.
REQ-027 SHALL handle simultaneous push and pop at occupancy 1: occupancy stays 1, new entry becomes head next cycle.
REQ-028 SHALL ignore push attempts while in_ready=0; in/imm_sel are don't-care when no push occurs.
REQ-029 SHALL hold out/illegal stable while out_valid=1 and out_ready=0.
REQ-030 SHALL wrap read/write pointers modulo 2 without loss.

Reset
REQ-031 SHALL, while rst_n=0, force occupancy 0, pointers 0, out_valid=0, in_ready=1, out=0, illegal=0, regardless of clk.
REQ-032 SHALL discard all buffered entries if reset asserts mid-operation; the first push after rst_n deasserts is treated as into an empty FIFO.

Verification
REQ-033 SHALL cover I-type: XLEN=32, push in=0xFFF00093, imm_sel=000, out_ready=1 -> next cycle out_valid=1, out=0xFFFFFFFF, illegal=0.
REQ-034 SHALL cover B-type: push in=0xFE000EE3, imm_sel=011 -> out=0xFFFFFFFC.
REQ-035 SHALL cover XLEN=64 U-type: push in=0x800000B7, imm_sel=001 -> out=0xFFFFFFFF80000000.
REQ-036 SHALL cover backpressure: out_ready=0, push A,B,C on consecutive cycles -> in_ready=0 after B, C not accepted; out_ready=1 -> A then B popped in order, in_ready returns 1.
REQ-037 SHALL cover illegal and Z: imm_sel=111 -> out=0, illegal=1; in=0x000FD073 with imm_sel=101 -> out=0x1F, illegal=0.
REQ-038 SHALL cover reset mid-operation: FIFO full, rst_n low between edges -> out_valid=0, in_ready=1 immediately, no stale output after release.
